// File: rtl/usb_bit_sampler_pkg.sv
// Shared USB full-speed receive definitions: line-state encoding and
// oversampling constants used by the bit sampler and the NRZI decoder.
package usb_bit_sampler_pkg;

    typedef enum logic [1:0] {
        SE0 = 2'd0,
        J   = 2'd1,
        K   = 2'd2,
        SE1 = 2'd3
    } usb_line_state_t;

    localparam int OVERSAMPLE = 4;

    localparam usb_line_state_t LINE_RESET = J;
    localparam bit LINE_RESET_DP = 1'b1;
    localparam bit LINE_RESET_DN = 1'b0;

    // {dp,dn}: 00 SE0, 10 J, 01 K, 11 SE1
    function automatic usb_line_state_t decode_pins(input logic dp, input logic dn);
        return usb_line_state_t'({dn, dp});
    endfunction

endpackage

// File: rtl/usb_input_sync.sv
// Per-pin input register: a single flop when the pad is already registered,
// otherwise a two-flop synchroniser followed by the line-state flop.
module usb_input_sync #(
    parameter bit REGISTERED_INPUT = 1'b1,
    parameter bit RESET_LEVEL      = 1'b0
) (
    input  logic clk48,
    input  logic rst_n,
    input  logic pin,
    output logic pin_sync
);

    generate
        if (REGISTERED_INPUT) begin : g_reg
            always_ff @(posedge clk48) begin
                if (!rst_n) pin_sync <= RESET_LEVEL;
                else        pin_sync <= pin;
            end
        end else begin : g_sync
            logic s1_p0;
            logic s2_p1;

            always_ff @(posedge clk48) begin
                if (!rst_n) begin
                    s1_p0    <= RESET_LEVEL;
                    s2_p1    <= RESET_LEVEL;
                    pin_sync <= RESET_LEVEL;
                end else begin
                    s1_p0    <= pin;
                    s2_p1    <= s1_p0;
                    pin_sync <= s2_p1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/usb_bit_sampler.sv
// Full-speed USB receive front end: synchronises D+/D-, tracks edges with a
// phase counter and emits one mid-bit strobe per recovered bit.
module usb_bit_sampler
    import usb_bit_sampler_pkg::*;
#(
    parameter bit REGISTERED_INPUT = 1'b1,
    parameter int SAMPLE_PHASE     = 2
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       dp_i,
    input  logic       dn_i,
    input  logic       err_clr_i,
    output logic       sample_valid_o,
    output logic [1:0] line_state_o,
    output logic       se1_err_o
);

    localparam int                PHASE_W  = $clog2(OVERSAMPLE);
    localparam logic [PHASE_W-1:0] SAMPLE_P = PHASE_W'(SAMPLE_PHASE);

    logic            dp_sync;
    logic            dn_sync;
    usb_line_state_t cur_p0;
    usb_line_state_t prev_p1;
    logic [PHASE_W-1:0] phase;
    logic            transition;
    logic            sample_hit;

    usb_input_sync #(
        .REGISTERED_INPUT(REGISTERED_INPUT),
        .RESET_LEVEL     (LINE_RESET_DP)
    ) u_sync_dp (
        .clk48   (clk48),
        .rst_n   (rst_n),
        .pin     (dp_i),
        .pin_sync(dp_sync)
    );

    usb_input_sync #(
        .REGISTERED_INPUT(REGISTERED_INPUT),
        .RESET_LEVEL     (LINE_RESET_DN)
    ) u_sync_dn (
        .clk48   (clk48),
        .rst_n   (rst_n),
        .pin     (dn_i),
        .pin_sync(dn_sync)
    );

    // Stage p0: decoded line state; p1: previous state for edge detection
    always_comb begin
        cur_p0     = decode_pins(dp_sync, dn_sync);
        transition = (cur_p0 != prev_p1);
        // An edge landing on the sample phase wins: the bit is taken later
        sample_hit = (phase == SAMPLE_P) && !transition;
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            prev_p1        <= LINE_RESET;
            phase          <= '0;
            sample_valid_o <= 1'b0;
            line_state_o   <= LINE_RESET;
            se1_err_o      <= 1'b0;
        end else begin
            prev_p1        <= cur_p0;
            phase          <= transition ? PHASE_W'(1) : phase + PHASE_W'(1);
            sample_valid_o <= sample_hit;
            if (sample_hit) line_state_o <= cur_p0;
            if (sample_hit && (cur_p0 == SE1)) se1_err_o <= 1'b1;
            else if (err_clr_i)                se1_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_bit_sampler.sv
// Scoreboard bench for usb_bit_sampler: registered-input and synchroniser
// builds driven side by side from the same pad stimulus.
module tb_usb_bit_sampler;
    import usb_bit_sampler_pkg::*;

    typedef struct {
        int         dut;
        int         cyc;
        logic [1:0] ls;
    } ev_t;

    logic       clk48;
    logic       rst_n;
    logic       dp_i;
    logic       dn_i;
    logic       err_clr_i;
    logic       sv0, sv1;
    logic [1:0] ls0, ls1;
    logic       err0, err1;

    int  n_checks;
    int  n_fail;
    int  cyc;
    bit  mon_en;
    ev_t sb[$];
    ev_t log_q[$];

    usb_line_state_t m_cur[2];
    usb_line_state_t m_prev[2];
    usb_line_state_t m_s1[2];
    usb_line_state_t m_s2[2];
    int              m_k[2];
    logic            m_flag[2];
    logic [1:0]      m_ls[2];

    usb_bit_sampler #(.REGISTERED_INPUT(1'b1), .SAMPLE_PHASE(2)) dut_ri1 (
        .clk48(clk48), .rst_n(rst_n), .dp_i(dp_i), .dn_i(dn_i), .err_clr_i(err_clr_i),
        .sample_valid_o(sv0), .line_state_o(ls0), .se1_err_o(err0)
    );

    usb_bit_sampler #(.REGISTERED_INPUT(1'b0), .SAMPLE_PHASE(2)) dut_ri0 (
        .clk48(clk48), .rst_n(rst_n), .dp_i(dp_i), .dn_i(dn_i), .err_clr_i(err_clr_i),
        .sample_valid_o(sv1), .line_state_o(ls1), .se1_err_o(err1)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, $signed(obs), $signed(exp), cyc);
        end
    endtask

    // Reference: k counts cycles since the last edge cycle; sample when k mod 4 == 2
    task automatic model_edge(input int d, input usb_line_state_t pad, input logic clr, input logic rstn);
        logic trans;
        logic samp;
        ev_t  e;
        if (!rstn) begin
            m_cur[d] = J; m_prev[d] = J; m_s1[d] = J; m_s2[d] = J;
            m_k[d] = 0; m_flag[d] = 1'b0; m_ls[d] = J;
        end else begin
            trans = (m_cur[d] != m_prev[d]);
            samp  = !trans && ((m_k[d] % OVERSAMPLE) == 2);
            if (samp) begin
                m_ls[d] = m_cur[d];
                e.dut = d; e.cyc = cyc; e.ls = m_cur[d];
                sb.push_back(e);
            end
            if (samp && (m_cur[d] == SE1)) m_flag[d] = 1'b1;
            else if (clr)                  m_flag[d] = 1'b0;
            m_k[d]    = trans ? 1 : m_k[d] + 1;
            m_prev[d] = m_cur[d];
            if (d == 0) begin
                m_cur[d] = pad;
            end else begin
                m_cur[d] = m_s2[d];
                m_s2[d]  = m_s1[d];
                m_s1[d]  = pad;
            end
        end
    endtask

    task automatic step(input usb_line_state_t ls, input logic clr, input logic rstn);
        case (ls)
            SE0:     begin dp_i = 1'b0; dn_i = 1'b0; end
            J:       begin dp_i = 1'b1; dn_i = 1'b0; end
            K:       begin dp_i = 1'b0; dn_i = 1'b1; end
            default: begin dp_i = 1'b1; dn_i = 1'b1; end
        endcase
        err_clr_i = clr;
        rst_n     = rstn;
        @(posedge clk48);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) model_edge(d, ls, clr, rstn);
    endtask

    task automatic settle();
        @(negedge clk48);
        #1;
    endtask

    function automatic int count_strb(input int d, input int lo, input int hi);
        int n;
        n = 0;
        foreach (log_q[i])
            if (log_q[i].dut == d && log_q[i].cyc >= lo && log_q[i].cyc <= hi) n++;
        return n;
    endfunction

    function automatic int first_strb(input int d, input int lo, input int want_ls);
        foreach (log_q[i])
            if (log_q[i].dut == d && log_q[i].cyc >= lo && (want_ls < 0 || int'(log_q[i].ls) == want_ls))
                return log_q[i].cyc;
        return -1;
    endfunction

    function automatic int strb_state(input int d, input int c);
        foreach (log_q[i])
            if (log_q[i].dut == d && log_q[i].cyc == c) return int'(log_q[i].ls);
        return -1;
    endfunction

    always @(negedge clk48) begin
        logic       v;
        logic [1:0] lo;
        logic       f;
        int         idx;
        ev_t        e;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                v  = (d == 0) ? sv0 : sv1;
                lo = (d == 0) ? ls0 : ls1;
                f  = (d == 0) ? err0 : err1;
                idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (idx < 0 && sb[i].dut == d) idx = i;
                if (v === 1'b1) begin
                    e.dut = d; e.cyc = cyc; e.ls = lo;
                    log_q.push_back(e);
                    if (idx < 0) begin
                        chk($sformatf("unexpected_strobe[%0d]", d), 32'(v), 32'd0);
                    end else begin
                        chk($sformatf("strobe_cycle[%0d]", d), cyc, sb[idx].cyc);
                        chk($sformatf("strobe_state[%0d]", d), 32'(lo), 32'(sb[idx].ls));
                        sb.delete(idx);
                    end
                end else if (idx >= 0 && sb[idx].cyc <= cyc) begin
                    chk($sformatf("missing_strobe[%0d]", d), 32'(v), 32'd1);
                    sb.delete(idx);
                end
                chk($sformatf("line_state[%0d]", d), 32'(lo), 32'(m_ls[d]));
                chk($sformatf("se1_err[%0d]", d), 32'(f), 32'(m_flag[d]));
            end
        end
    end

    initial begin
        int              r, c0, cs, a, b, rr, t0, t1, n, len;
        usb_line_state_t st;
        logic [1:0]      jexp [5];

        n_checks = 0; n_fail = 0; cyc = 0; mon_en = 1'b0;
        rst_n = 1'b0; dp_i = 1'b1; dn_i = 1'b0; err_clr_i = 1'b0;
        for (int d = 0; d < 2; d++) model_edge(d, J, 1'b0, 1'b0);

        step(J, 1'b0, 1'b0);
        step(J, 1'b0, 1'b0);
        mon_en = 1'b1;
        chk("rst_valid0", 32'(sv0), 32'd0);
        chk("rst_state0", 32'(ls0), 32'(J));
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_valid1", 32'(sv1), 32'd0);
        chk("rst_state1", 32'(ls1), 32'(J));
        chk("rst_err1", 32'(err1), 32'd0);

        // idle J: strobe every fourth cycle
        r = cyc;
        repeat (16) step(J, 1'b0, 1'b1);
        settle();
        chk("idle_strobes0", count_strb(0, r + 1, r + 16), 4);
        chk("idle_strobes1", count_strb(1, r + 1, r + 16), 4);

        // alternating J/K, four cycles per bit
        c0 = cyc;
        repeat (4) begin
            repeat (4) step(K, 1'b0, 1'b1);
            repeat (4) step(J, 1'b0, 1'b1);
        end
        settle();
        t0 = first_strb(0, c0 + 1, int'(K));
        t1 = first_strb(1, c0 + 1, int'(K));
        chk("first_strobe_lat_ri1", t0 - c0, 4);
        chk("sync_extra_lat", t1 - t0, 2);
        chk("alt_strobes0", count_strb(0, c0 + 4, c0 + 32), 8);

        // jitter: bit lengths 3,5,4,3,5
        cs = cyc;
        repeat (3) step(K, 1'b0, 1'b1);
        repeat (5) step(J, 1'b0, 1'b1);
        repeat (4) step(K, 1'b0, 1'b1);
        repeat (3) step(J, 1'b0, 1'b1);
        repeat (5) step(K, 1'b0, 1'b1);
        repeat (2) step(J, 1'b0, 1'b1);
        settle();
        chk("jitter_count", count_strb(0, cs + 1, cs + 22), 5);
        jexp[0] = K; jexp[1] = J; jexp[2] = K; jexp[3] = J; jexp[4] = K;
        n = 0;
        foreach (log_q[i]) begin
            if (log_q[i].dut == 0 && log_q[i].cyc >= cs + 1 && log_q[i].cyc <= cs + 22 && n < 5) begin
                chk($sformatf("jitter_state%0d", n), 32'(log_q[i].ls), 32'(jexp[n]));
                n++;
            end
        end
        repeat (6) step(J, 1'b0, 1'b1);

        // 6-cycle K bit puts the following edge on phase 2
        a = cyc;
        repeat (6) step(K, 1'b0, 1'b1);
        repeat (8) step(J, 1'b0, 1'b1);
        settle();
        chk("p2_edge_no_strobe", count_strb(0, a + 5, a + 9), 0);
        chk("p2_edge_next_strobe", first_strb(0, a + 5, -1), a + 10);
        chk("p2_edge_next_state", strb_state(0, a + 10), int'(J));

        // SE1 bit, sticky flag, clear, and set-beats-clear
        b = cyc;
        repeat (4) step(SE1, 1'b0, 1'b1);
        repeat (8) step(J, 1'b0, 1'b1);
        settle();
        chk("se1_strobe_state", strb_state(0, b + 4), int'(SE1));
        chk("se1_sticky0", 32'(err0), 32'd1);
        chk("se1_sticky1", 32'(err1), 32'd1);
        step(J, 1'b1, 1'b1);
        chk("se1_clear0", 32'(err0), 32'd0);
        chk("se1_clear1", 32'(err1), 32'd0);
        for (int i = 0; i < 4; i++) step(SE1, (i == 3), 1'b1);
        chk("se1_set_wins0", 32'(err0), 32'd1);
        repeat (8) step(J, 1'b0, 1'b1);
        chk("se1_late_set1", 32'(err1), 32'd1);

        // reset pulse in the middle of a K bit
        repeat (2) step(K, 1'b0, 1'b1);
        step(K, 1'b0, 1'b0);
        rr = cyc;
        chk("midrst_valid0", 32'(sv0), 32'd0);
        chk("midrst_state0", 32'(ls0), 32'(J));
        chk("midrst_err0", 32'(err0), 32'd0);
        chk("midrst_valid1", 32'(sv1), 32'd0);
        chk("midrst_state1", 32'(ls1), 32'(J));
        chk("midrst_err1", 32'(err1), 32'd0);
        repeat (8) step(K, 1'b0, 1'b1);
        repeat (8) step(J, 1'b0, 1'b1);
        settle();
        chk("resync_lat_ri1", first_strb(0, rr + 1, int'(K)) - rr, 4);
        chk("resync_lat_ri0", first_strb(1, rr + 1, int'(K)) - rr, 6);

        // random bit lengths 3..5, then an SE0 end-of-packet and idle
        st = K;
        for (int i = 0; i < 30; i++) begin
            len = $urandom_range(5, 3);
            repeat (len) step(st, 1'b0, 1'b1);
            st = (st == K) ? J : K;
        end
        repeat (8) step(SE0, 1'b0, 1'b1);
        repeat (12) step(J, 1'b0, 1'b1);
        settle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_bit_sampler.md
# usb_bit_sampler

Front-end receive stage of the full-speed USB device controller, directly downstream of the D+/D- input pads. Runs on the 48 MHz PLL clock (4x oversampling of 12 Mbit/s), synchronises the differential pins, decodes the line state, tracks signal edges with a 2-bit phase counter and emits exactly one mid-bit sample strobe per recovered bit. Its output feeds the NRZI decoder and bit-unstuffer. It also exports a sticky SE1 error flag for the debug LEDs.

## Interface
- REGISTERED_INPUT, default 1: 1 = pads already register D+/D- in the IO block, so one internal flop is used; 0 = a two-flop synchroniser is inserted first.
- SAMPLE_PHASE, default 2: phase counter value at which the bit is sampled.
- clk48  in  1  48 MHz PLL clock, the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- dp_i  in  1  D+ pad input.
- dn_i  in  1  D- pad input.
- err_clr_i  in  1  single-cycle clear of the se1_err_o flag.
- sample_valid_o  out  1  one-cycle strobe: a bit has been recovered.
- line_state_o  out  2  recovered line state, valid while sample_valid_o=1 and held otherwise.
- se1_err_o  out  1  sticky flag: an SE1 state was sampled.

## Operation
- Line state encoding: {dp,dn}=00 SE0 (0), 10 J (1), 01 K (2), 11 SE1 (3).
- Sync path: REGISTERED_INPUT=1 → cur <= {dp_i,dn_i}; REGISTERED_INPUT=0 → s1 → s2 → cur. prev <= cur every cycle.
- transition = (cur != prev).
- Phase counter p, 2 bits, wraps 3→0:
  - transition → p <= 1. The edge cycle counts as phase 0.
  - otherwise → p <= p+1.
- Sample condition: p == SAMPLE_PHASE and no transition in that cycle. At the next edge, sample_valid_o <= 1 and line_state_o <= cur. Otherwise sample_valid_o <= 0 and line_state_o holds.
- Edge coinciding with p == SAMPLE_PHASE: the transition has priority. No strobe is issued and p <= 1. The bit is recovered at the next phase-2 cycle.
- No edges (long run of identical states, including SE0/EOP and idle J): a strobe is issued every 4 cycles.
- se1_err_o: set when a strobe carries SE1. Cleared by err_clr_i. If set and clear happen in the same cycle, set wins.
- Reset values: cur, prev, s1 and s2 = J; p = 0; sample_valid_o = 0; line_state_o = J; se1_err_o = 0. A reset mid-bit discards the bit in progress. Phase lock is reacquired at the first edge after reset.

## Timing
- Latency from a pad edge to the first strobe for the new state:
  - REGISTERED_INPUT=1: pad change at cycle t (sampled into cur at t+1) → p=1 at t+2, p=2 at t+3 → sample_valid_o high at t+4. Pads already registered externally add one further cycle outside this block.
  - REGISTERED_INPUT=0: the same sequence plus 2 cycles.
- Steady-state strobe spacing is 4 cycles. An edge jitter of ±1 cycle gives spacing 3 or 5, and every bit is still strobed exactly once.
- No backpressure: the downstream stage must accept every strobe.

## Structure
- The shared package holds:
  - the usb_line_state_t enum {SE0, J, K, SE1} (2 bits);
  - OVERSAMPLE = 4;
  - the reset line state J.
- The NRZI decoder reuses the same enum.
- One natural sub-module is usb_input_sync: a parameterised 1/2-flop synchroniser per pin, reset to J levels.
- The phase logic and the SE1 flag stay in the top module.

## Test plan
- Idle J after reset, no edges → sample_valid_o every 4th cycle, line_state_o=J, se1_err_o=0.
- Alternating J/K, 4 cycles each (REGISTERED_INPUT=1) → strobes 4 cycles apart, line_state_o alternates J,K,J,K; first strobe exactly 3 cycles after cur changes.
- Jitter pattern of bit lengths 3,5,4,3,5 cycles → exactly 5 strobes with the correct states; no duplicated or dropped bit.
- Edge forced at p==2 → no strobe that cycle, p restarts at 1, next strobe 2 cycles later with the new state.
- SE1 held for 4 cycles → one strobe with line_state_o=3 and se1_err_o=1 stays high; err_clr_i pulse → 0; simultaneous SE1 strobe and clear → stays 1.
- rst_n low for 1 cycle mid-bit during K → next cycle all outputs at reset values; resync to p=1 on the next edge; REGISTERED_INPUT=0 build shows +2 cycle latency.
